// File: rtl/itof_pipe_if.sv
// Handshake bundle for the integer-to-binary32 converter: an input
// valid/ready channel carrying the operand and its signedness, and an output
// valid/ready channel carrying the packed result and its inexact flag.
interface itof_pipe_if #(
    parameter int IW = 32
) ();
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          in_signed;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_inexact;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

    // Converter side
    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/itof_pipe.sv
// Three-stage pipelined integer to IEEE-754 binary32 converter.
// S1 captures sign and magnitude, S2 normalises with a leading-zero count,
// S3 rounds (nearest-even or truncate) and packs. A bubble-collapsing ready
// chain lets any empty stage absorb a new entry even while the output stalls.
module itof_pipe #(
    parameter int IW    = 32,
    parameter int ROUND = 1
) (
    input  logic        clk,
    input  logic        rstn,
    itof_pipe_if.slave  bus
);
    localparam int   LW    = $clog2(IW + 1);
    // Extended fraction window: at least 23 frac bits + guard + one sticky bit
    localparam int   XW    = (IW - 1 > 25) ? IW - 1 : 25;
    localparam logic P_RND = (ROUND != 0);

    // Stage registers
    logic          r_v1, r_v2, r_v3;
    logic          r_sign1, r_sign2;
    logic [IW-1:0] r_mag1;
    logic [IW-1:0] r_norm2;
    logic [7:0]    r_exp2;
    logic [31:0]   r_data3;
    logic          r_inexact3;

    // Combinational nets
    logic          w_en1, w_en2, w_en3;
    logic          w_sign_in;
    logic [IW-1:0] w_mag_in;
    logic [LW-1:0] w_lzc;
    logic [IW-1:0] w_norm;
    logic [7:0]    w_exp;
    logic [XW-1:0] w_ext;
    logic [22:0]   w_frac;
    logic          w_guard;
    logic          w_sticky;
    logic          w_inc;
    logic [23:0]   w_frac_rnd;
    logic [7:0]    w_exp_out;
    logic [31:0]   w_data;
    logic          w_inexact;

    // Ready chain: a stage may load if downstream moves or it is empty
    assign w_en3        = bus.out_ready | ~r_v3;
    assign w_en2        = w_en3 | ~r_v2;
    assign w_en1        = w_en2 | ~r_v1;
    assign bus.in_ready = w_en1;

    assign bus.out_valid   = r_v3;
    assign bus.out_data    = r_data3;
    assign bus.out_inexact = r_inexact3;

    // S1 input: sign and magnitude (most negative value maps to 2^(IW-1))
    always_comb begin
        w_sign_in = bus.in_signed & bus.in_data[IW-1];
        if (w_sign_in) begin
            w_mag_in = IW'(0) - bus.in_data;
        end else begin
            w_mag_in = bus.in_data;
        end
    end

    // S2 input: leading-zero count, normalised mantissa and unbiased exponent
    always_comb begin
        w_lzc = LW'(IW);
        for (int i = 0; i < IW; i++) begin
            w_lzc = r_mag1[i] ? LW'(IW - 1 - i) : w_lzc;
        end
        w_norm = r_mag1 << w_lzc;
        w_exp  = 8'(IW - 1) - 8'(w_lzc);
    end

    // S3 input: fraction extraction, guard/sticky, rounding and packing.
    // The top bit of the normalised value is the hidden one; it is clear
    // only for a zero operand, which packs to +0.
    always_comb begin
        w_ext                  = '0;
        w_ext[XW-1 -: IW-1]    = r_norm2[IW-2:0];
        w_frac                 = w_ext[XW-1 -: 23];
        w_guard                = w_ext[XW-24];
        w_sticky               = |w_ext[XW-25:0];
        w_inc                  = P_RND & w_guard & (w_sticky | w_frac[0]);
        w_frac_rnd             = {1'b0, w_frac} + {23'd0, w_inc};
        w_exp_out              = 8'd127 + r_exp2 + {7'd0, w_frac_rnd[23]};
        if (r_norm2[IW-1]) begin
            w_data    = {r_sign2, w_exp_out, w_frac_rnd[22:0]};
            w_inexact = w_guard | w_sticky;
        end else begin
            w_data    = 32'h0000_0000;
            w_inexact = 1'b0;
        end
    end

    // Valid bits advance along the ready chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_en1) r_v1 <= bus.in_valid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) r_v3 <= r_v2;
        end
    end

    // S1 capture registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sign1 <= 1'b0;
            r_mag1  <= '0;
        end else if (w_en1) begin
            r_sign1 <= w_sign_in;
            r_mag1  <= w_mag_in;
        end
    end

    // S2 normalise registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sign2 <= 1'b0;
            r_norm2 <= '0;
            r_exp2  <= 8'd0;
        end else if (w_en2) begin
            r_sign2 <= r_sign1;
            r_norm2 <= w_norm;
            r_exp2  <= w_exp;
        end
    end

    // S3 result registers; hold while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data3    <= 32'h0000_0000;
            r_inexact3 <= 1'b0;
        end else if (w_en3) begin
            r_data3    <= w_data;
            r_inexact3 <= w_inexact;
        end
    end
endmodule
